segment_sequencer: RTL and testbench

Single-clock controller that sequences waveform parameter loading and segment playback for the 64-channel synthesis block. It arbitrates the three host parameter streams (amplitude, offset, phase word) onto one shared shadow-bank write port, tracks when a full parameter set is loaded, and issues a one-cycle commit that copies shadow to active. After each commit it times the segment and chains the next one when loop mode is on.

---
 rtl/segment_sequencer.sv | 159 +++++++++++++++
 tb/tb_segment_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_sequencer.sv
// segment_sequencer: shares one shadow-bank write port among three parameter streams
// and sequences commit/playback segments with optional looping.
module segment_sequencer #(
   parameter int NUM_BLOCKS = 64,
   parameter int AW         = 6,
   parameter int DW         = 16
) (
   input  logic          clk_i,
   input  logic          reset_n_i,
   input  logic          amp_write_i,
   input  logic [DW-1:0] amp_data_i,
   input  logic          offset_write_i,
   input  logic [DW-1:0] offset_data_i,
   input  logic          phase_write_i,
   input  logic [DW-1:0] phase_data_i,
   input  logic          start_i,
   input  logic          stop_i,
   input  logic          force_i,
   input  logic          loop_mode_i,
   input  logic [15:0]   duration_i,
   output logic          wr_en_o,
   output logic [1:0]    wr_sel_o,
   output logic [AW-1:0] wr_addr_o,
   output logic [DW-1:0] wr_data_o,
   output logic          commit_o,
   output logic          seg_done_o,
   output logic          ready_o,
   output logic          busy_o,
   output logic [1:0]    state_o,
   output logic [2:0]    overflow_o
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;
   localparam logic [1:0] S_RUN    = 2'd3;
   localparam logic [AW:0] FULL    = NUM_BLOCKS[AW:0];

   logic [1:0]    state_q, state_d;
   logic [15:0]   rem_q, rem_d;
   logic [1:0]    last_q;
   logic [AW:0]   count_q [3];
   logic [AW:0]   count_d [3];
   logic [2:0]    hold_v_q, hold_v_d;
   logic [DW-1:0] hold_data_q [3];
   logic [DW-1:0] hold_data_d [3];
   logic          wr_en_q;
   logic [1:0]    wr_sel_q, wr_sel_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [DW-1:0] wr_data_q, wr_data_d;
   logic          ready_q, ready_d;
   logic [2:0]    ovf_q, ovf_d;

   logic [2:0]    stb;
   logic [DW-1:0] din [3];
   logic [3:0]    elig;
   logic [1:0]    p0, p1, gnt;
   logic          gnt_v, go, do_commit, seg_end, acc_start;
   logic [AW:0]   gnt_cnt;
   logic [DW-1:0] gnt_data;
   logic [2:0]    drop;

   function automatic logic [1:0] rr_next(input logic [1:0] s);
      return s == 2'd2 ? 2'd0 : s + 2'd1;
   endfunction

   assign stb    = {phase_write_i, offset_write_i, amp_write_i};
   assign din[0] = amp_data_i;
   assign din[1] = offset_data_i;
   assign din[2] = phase_data_i;

   assign go        = reset_n_i && !stop_i;
   assign do_commit = go && state_q == S_COMMIT;
   assign seg_end   = go && state_q == S_RUN && (rem_q == '0 || force_i);
   assign acc_start = go && state_q == S_IDLE && start_i;

   // Round-robin: search begins at the stream after the one served last.
   assign elig[3] = 1'b0;
   assign p0      = rr_next(last_q);
   assign p1      = rr_next(p0);
   assign gnt_v   = |elig[2:0];
   assign gnt     = elig[p0] ? p0 : elig[p1] ? p1 : last_q;
   assign gnt_cnt  = gnt == 2'd0 ? count_q[0] : gnt == 2'd1 ? count_q[1] : count_q[2];
   assign gnt_data = gnt == 2'd0 ? hold_data_q[0] : gnt == 2'd1 ? hold_data_q[1] : hold_data_q[2];

   for (genvar i = 0; i < 3; i++) begin : g_str
      logic        granted, take;
      logic [AW:0] base;
      assign elig[i] = hold_v_q[i] && count_q[i] < FULL && state_q != S_COMMIT;
      assign granted = gnt_v && gnt == 2'(i);
      // A commit empties the bank this cycle, so capture judges room against zero.
      assign base    = do_commit ? '0 : count_q[i];
      assign take    = stb[i] && (!hold_v_q[i] || granted) && (base + {{AW{1'b0}}, hold_v_q[i]}) < FULL;
      assign drop[i] = stb[i] && !take;
      assign hold_v_d[i]    = take || (hold_v_q[i] && !granted);
      assign hold_data_d[i] = take ? din[i] : hold_data_q[i];
      assign count_d[i]     = base + {{AW{1'b0}}, granted};
   end

   assign wr_sel_d  = gnt_v ? gnt : wr_sel_q;
   assign wr_addr_d = gnt_v ? gnt_cnt[AW-1:0] : wr_addr_q;
   assign wr_data_d = gnt_v ? gnt_data : wr_data_q;
   assign ready_d   = count_d[0] == FULL && count_d[1] == FULL && count_d[2] == FULL;
   assign ovf_d     = (acc_start ? 3'b000 : ovf_q) | drop;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      if (!go) state_d = S_IDLE;
      else if (state_q == S_IDLE) state_d = start_i ? (ready_q ? S_COMMIT : S_WAIT) : S_IDLE;
      else if (state_q == S_WAIT) state_d = ready_q ? S_COMMIT : S_WAIT;
      else if (state_q == S_COMMIT) begin
         state_d = S_RUN;
         rem_d   = duration_i;
      end
      else if (seg_end) state_d = loop_mode_i ? (ready_q ? S_COMMIT : S_WAIT) : S_IDLE;
      else rem_d = rem_q - 16'd1;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q     <= S_IDLE;
         rem_q       <= '0;
         last_q      <= 2'd2;
         count_q     <= '{default: '0};
         hold_v_q    <= '0;
         hold_data_q <= '{default: '0};
         wr_en_q     <= 1'b0;
         wr_sel_q    <= '0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         ready_q     <= 1'b0;
         ovf_q       <= '0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         last_q      <= gnt_v ? gnt : last_q;
         count_q     <= count_d;
         hold_v_q    <= hold_v_d;
         hold_data_q <= hold_data_d;
         wr_en_q     <= gnt_v;
         wr_sel_q    <= wr_sel_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         ready_q     <= ready_d;
         ovf_q       <= ovf_d;
      end
   end

   assign wr_en_o    = wr_en_q;
   assign wr_sel_o   = wr_sel_q;
   assign wr_addr_o  = wr_addr_q;
   assign wr_data_o  = wr_data_q;
   assign commit_o   = do_commit;
   assign seg_done_o = seg_end;
   assign ready_o    = ready_q;
   assign busy_o     = state_q != S_IDLE;
   assign state_o    = state_q;
   assign overflow_o = ovf_q;
endmodule

// File: tb/tb_segment_sequencer.sv
// tb_segment_sequencer: directed and randomized checks of segment_sequencer against
// a cycle-level behavioural model of the stream arbiter and segment sequencer.
module tb_segment_sequencer;
   logic        clk = 1'b0, reset_n = 1'b0;
   logic        amp_write = 1'b0, offset_write = 1'b0, phase_write = 1'b0;
   logic [15:0] amp_data = '0, offset_data = '0, phase_data = '0;
   logic        start = 1'b0, stop = 1'b0, frc = 1'b0, loop_mode = 1'b0;
   logic [15:0] duration = '0;
   logic        wr_en, commit, seg_done, ready, busy;
   logic [1:0]  wr_sel, state;
   logic [5:0]  wr_addr;
   logic [15:0] wr_data;
   logic [2:0]  overflow;

   int n_checks = 0, n_fail = 0;

   segment_sequencer dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .amp_write_i(amp_write), .amp_data_i(amp_data),
      .offset_write_i(offset_write), .offset_data_i(offset_data),
      .phase_write_i(phase_write), .phase_data_i(phase_data),
      .start_i(start), .stop_i(stop), .force_i(frc), .loop_mode_i(loop_mode),
      .duration_i(duration),
      .wr_en_o(wr_en), .wr_sel_o(wr_sel), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
      .commit_o(commit), .seg_done_o(seg_done), .ready_o(ready), .busy_o(busy),
      .state_o(state), .overflow_o(overflow)
   );

   always #5 clk = ~clk;

   // model state: words written per stream, pending word per stream, and playback phase
   int          m_cnt [3];
   int          m_hv [3];
   logic [15:0] m_hd [3];
   int          m_last, m_st, m_rem, m_sel, m_addr;
   bit          m_wen, m_ready, mv = 1'b0;
   logic [15:0] m_data;
   logic [2:0]  m_ovf;

   task automatic chk(input string n, input int a, input int e);
      n_checks++;
      if (a != e) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = 0;
         m_hv[i]  = 0;
         m_hd[i]  = '0;
      end
      m_last = 2; m_st = 0; m_rem = 0; m_sel = 0; m_addr = 0;
      m_wen = 0; m_ready = 0; m_data = '0; m_ovf = '0;
   endtask

   task automatic step();
      int          g;
      bit          live, cm, acs, rdy0;
      bit          take [3];
      bit          stb [3];
      logic [15:0] din [3];
      logic [2:0]  drop;
      if (!reset_n) begin
         m_reset();
         mv = 1'b1;
         return;
      end
      stb  = '{amp_write, offset_write, phase_write};
      din  = '{amp_data, offset_data, phase_data};
      live = !stop;
      cm   = live && m_st == 2;
      acs  = live && m_st == 0 && start;
      rdy0 = m_ready;
      g = -1;
      if (m_st != 2)
         for (int k = 1; k <= 3; k++)
            if (g < 0 && m_hv[(m_last + k) % 3] != 0 && m_cnt[(m_last + k) % 3] < 64) g = (m_last + k) % 3;
      drop = '0;
      for (int i = 0; i < 3; i++) begin
         take[i] = stb[i] && (m_hv[i] == 0 || g == i) && ((cm ? 0 : m_cnt[i]) + m_hv[i] < 64);
         drop[i] = stb[i] && !take[i];
      end
      m_wen = g >= 0;
      if (g >= 0) begin
         m_sel  = g;
         m_addr = m_cnt[g];
         m_data = m_hd[g];
         m_cnt[g]++;
         m_hv[g] = 0;
         m_last  = g;
      end
      for (int i = 0; i < 3; i++) begin
         if (cm) m_cnt[i] = 0;
         if (take[i]) begin
            m_hv[i] = 1;
            m_hd[i] = din[i];
         end
      end
      m_ovf   = (acs ? 3'b000 : m_ovf) | drop;
      m_ready = m_cnt[0] == 64 && m_cnt[1] == 64 && m_cnt[2] == 64;
      if (!live) m_st = 0;
      else case (m_st)
         0: if (start) m_st = rdy0 ? 2 : 1;
         1: if (rdy0) m_st = 2;
         2: begin
            m_st  = 3;
            m_rem = int'(duration);
         end
         default: if (m_rem == 0 || frc) m_st = loop_mode ? (rdy0 ? 2 : 1) : 0;
                  else m_rem--;
      endcase
   endtask

   always @(negedge clk) begin
      if (mv) begin
         chk("state", int'(state), m_st);
         chk("busy", int'(busy), int'(m_st != 0));
         chk("ready", int'(ready), int'(m_ready));
         chk("overflow", int'(overflow), int'(m_ovf));
         chk("wr_en", int'(wr_en), int'(m_wen));
         chk("wr_sel", int'(wr_sel), m_sel);
         chk("wr_addr", int'(wr_addr), m_addr);
         chk("wr_data", int'(wr_data), int'(m_data));
         chk("commit", int'(commit), int'(reset_n && !stop && m_st == 2));
         chk("seg_done", int'(seg_done), int'(reset_n && !stop && m_st == 3 && (m_rem == 0 || frc)));
      end
      step();
   end

   task automatic nxt();
      @(posedge clk);
      #1;
      {amp_write, offset_write, phase_write, start, stop, frc} = '0;
   endtask

   task automatic drive(input int s, input logic [15:0] d);
      if (s == 0) begin amp_write = 1'b1; amp_data = d; end
      else if (s == 1) begin offset_write = 1'b1; offset_data = d; end
      else begin phase_write = 1'b1; phase_data = d; end
   endtask

   task automatic fill(input int s);
      int n;
      n = 64 - m_cnt[s] - m_hv[s];
      for (int j = 0; j < n; j++) begin
         nxt();
         drive(s, 16'($urandom));
      end
      repeat (4) nxt();
   endtask

   task automatic fill_all();
      fill(0);
      fill(1);
      fill(2);
   endtask

   task automatic wait_state(input int s);
      bit hit = 1'b0;
      for (int k = 0; k < 40 && !hit; k++) begin
         @(negedge clk);
         hit = int'(state) == s;
         if (!hit) nxt();
      end
      chk("lit_wait_state", int'(hit), 1);
   endtask

   initial begin
      reset_n = 1'b0;
      repeat (3) nxt();
      @(negedge clk);
      chk("lit_rst_state", int'(state), 0);
      chk("lit_rst_wr_en", int'(wr_en), 0);
      chk("lit_rst_addr", int'(wr_addr), 0);
      chk("lit_rst_data", int'(wr_data), 0);
      chk("lit_rst_ready", int'(ready), 0);
      chk("lit_rst_ovf", int'(overflow), 0);
      nxt();
      reset_n = 1'b1;
      // 64 back-to-back amp words: each written two cycles after its strobe
      for (int k = 0; k < 66; k++) begin
         nxt();
         if (k < 64) drive(0, 16'(k));
         @(negedge clk);
         chk("lit_amp_wr_en", int'(wr_en), int'(k >= 2));
         if (k >= 2) begin
            chk("lit_amp_sel", int'(wr_sel), 0);
            chk("lit_amp_addr", int'(wr_addr), k - 2);
            chk("lit_amp_data", int'(wr_data), k - 2);
         end
      end
      chk("lit_amp_ready", int'(ready), 0);
      chk("lit_amp_ovf", int'(overflow), 0);
      fill(1);
      fill(2);
      @(negedge clk);
      chk("lit_full_ready", int'(ready), 1);
      // single segment, duration 5
      nxt();
      start = 1'b1; duration = 16'd5; loop_mode = 1'b0;
      @(negedge clk);
      chk("lit_seg_idle", int'(state), 0);
      nxt();
      @(negedge clk);
      chk("lit_seg_commit", int'(commit), 1);
      for (int r = 0; r < 6; r++) begin
         nxt();
         @(negedge clk);
         chk("lit_seg_run", int'(state), 3);
         chk("lit_seg_done", int'(seg_done), int'(r == 5));
      end
      nxt();
      @(negedge clk);
      chk("lit_seg_end_state", int'(state), 0);
      chk("lit_seg_end_ready", int'(ready), 0);
      // three streams in one cycle: served amp, offset, phase
      nxt();
      drive(0, 16'hA000); drive(1, 16'hB000); drive(2, 16'hC000);
      for (int k = 1; k <= 4; k++) begin
         nxt();
         @(negedge clk);
         if (k >= 2) begin
            chk("lit_rr_sel", int'(wr_sel), k - 2);
            chk("lit_rr_data", int'(wr_data), k == 2 ? 'hA000 : k == 3 ? 'hB000 : 'hC000);
         end
      end
      // two back-to-back triples: the second offset/phase words are dropped
      nxt();
      drive(0, 16'hA001); drive(1, 16'hB001); drive(2, 16'hC001);
      nxt();
      drive(0, 16'hA002); drive(1, 16'hB002); drive(2, 16'hC002);
      for (int k = 2; k <= 5; k++) begin
         nxt();
         @(negedge clk);
         chk("lit_drop_sel", int'(wr_sel), k == 5 ? 0 : k - 2);
         chk("lit_drop_data", int'(wr_data), k == 2 ? 'hA001 : k == 3 ? 'hB001 : k == 4 ? 'hC001 : 'hA002);
         chk("lit_drop_ovf", int'(overflow), 3'b110);
      end
      // 65th amp word overflows
      fill_all();
      nxt();
      drive(0, 16'hDEAD);
      nxt();
      @(negedge clk);
      chk("lit_ovf65", int'(overflow), 3'b111);
      chk("lit_ovf65_ready", int'(ready), 1);
      // looping segment with no reload falls into WAIT_LOAD
      nxt();
      start = 1'b1; loop_mode = 1'b1; duration = 16'd3;
      @(negedge clk);
      nxt();
      @(negedge clk);
      chk("lit_loop_commit", int'(commit), 1);
      chk("lit_loop_ovf_clr", int'(overflow), 0);
      for (int r = 0; r < 4; r++) begin
         nxt();
         @(negedge clk);
         chk("lit_loop_run", int'(state), 3);
         chk("lit_loop_done", int'(seg_done), int'(r == 3));
      end
      nxt();
      @(negedge clk);
      chk("lit_loop_wait", int'(state), 1);
      // reload completes the wait; then force ends a long segment early
      loop_mode = 1'b0; duration = 16'd100;
      fill_all();
      wait_state(3);
      nxt();
      frc = 1'b1;
      @(negedge clk);
      chk("lit_force_state", int'(state), 3);
      chk("lit_force_done", int'(seg_done), 1);
      nxt();
      @(negedge clk);
      chk("lit_force_idle", int'(state), 0);
      // force together with stop: no seg_done
      fill_all();
      nxt();
      start = 1'b1;
      wait_state(3);
      nxt();
      frc = 1'b1; stop = 1'b1;
      @(negedge clk);
      chk("lit_stop_force_done", int'(seg_done), 0);
      nxt();
      @(negedge clk);
      chk("lit_stop_idle", int'(state), 0);
      // reset during RUN
      fill_all();
      nxt();
      start = 1'b1;
      wait_state(3);
      nxt();
      reset_n = 1'b0;
      @(negedge clk);
      chk("lit_rrun_commit", int'(commit), 0);
      nxt();
      reset_n = 1'b1;
      @(negedge clk);
      chk("lit_rrun_state", int'(state), 0);
      chk("lit_rrun_ready", int'(ready), 0);
      // randomized traffic against the model
      begin
         int dens [3];
         for (int c = 0; c < 4000; c++) begin
            nxt();
            if (c % 250 == 0) begin
               for (int i = 0; i < 3; i++) dens[i] = $urandom_range(0, 10);
               loop_mode = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 9) < dens[0]) drive(0, 16'($urandom));
            if ($urandom_range(0, 9) < dens[1]) drive(1, 16'($urandom));
            if ($urandom_range(0, 9) < dens[2]) drive(2, 16'($urandom));
            start    = $urandom_range(0, 15) == 0;
            stop     = $urandom_range(0, 79) == 0;
            frc      = $urandom_range(0, 29) == 0;
            duration = 16'($urandom_range(0, 7));
            reset_n  = $urandom_range(0, 1499) != 0;
         end
      end
      nxt();
      reset_n = 1'b1;
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
